fpu_cmp_issuer: RTL and testbench

- Front-end sequencer that drives the FPU's single-cycle pipelined compare unit (operand pair plus stage1_valid in; all-ones/all-zeros y plus out_valid out, one cycle later).
- Accepts FLE/FLT/FEQ requests from the core via valid/ready and maps each onto one or two less-or-equal beats.
- Tracks in-flight beats in order, combines feq halves and buffers results for a back-pressured writeback port.
- The compare unit cannot stall, so the issuer reserves result-buffer space before it issues any beat.

---
 rtl/fpu_cmp_issuer.sv | 254 +++++++++++++++++++++++++
 tb/tb_fpu_cmp_issuer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_cmp_issuer.sv
`default_nettype none
// ============================================================================
// Module   : fpu_cmp_issuer
// Function : FLE/FLT/FEQ sequencer feeding a pipelined less-or-equal compare
//            unit, with in-order result tracking and a buffered writeback.
//            Optional FPU_CMP_STATS_EN adds issue/stall counters.
// Revision : 1.0
// ============================================================================
module fpu_cmp_issuer #(
   parameter int TAG_W = 5,
   parameter int DEPTH = 4
) (
   input  logic             sys_clk,
   input  logic             rstn,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [TAG_W-1:0] req_tag,
   input  logic [31:0]      req_x1,
   input  logic [31:0]      req_x2,
   output logic             cmp_valid,
   output logic [31:0]      cmp_x1,
   output logic [31:0]      cmp_x2,
   input  logic [31:0]      cmp_y,
   input  logic             cmp_out_valid,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [TAG_W-1:0] wb_tag,
   output logic [31:0]      wb_data
`ifdef FPU_CMP_STATS_EN
   ,
   output logic [31:0]      stat_issued,
   output logic [31:0]      stat_stall
`endif
);

   localparam int PTR_W = $clog2(DEPTH);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ISSUE2 = 1'b1;

   localparam logic [1:0] KIND_FLE = 2'd0;
   localparam logic [1:0] KIND_FLT = 2'd1;
   localparam logic [1:0] KIND_FEQ = 2'd2;

   localparam logic [PTR_W:0]   DEPTH_C  = DEPTH[PTR_W:0];
   localparam logic [PTR_W:0]   ONE_W    = {{PTR_W{1'b0}}, 1'b1};
   localparam logic [PTR_W+1:0] ONE_PEND = {{(PTR_W+1){1'b0}}, 1'b1};

   logic [0:0]       state;
   logic [31:0]      lat_a;
   logic [31:0]      lat_b;
   logic [TAG_W-1:0] lat_tag;
   logic [1:0]       req_kind;
   logic             accept;

   // pending-beat FIFO (2*DEPTH entries: each request may need two beats)
   logic [TAG_W-1:0] pend_tag    [0:2*DEPTH-1];
   logic [1:0]       pend_kind   [0:2*DEPTH-1];
   logic             pend_second [0:2*DEPTH-1];
   logic [PTR_W:0]   pend_wr;
   logic [PTR_W:0]   pend_rd;
   logic [PTR_W+1:0] pend_count;
   logic             pend_push;
   logic             pend_pop;
   logic [TAG_W-1:0] push_tag;
   logic [1:0]       push_kind;
   logic             push_second;

   logic             hold;
   logic             res_push;
   logic             res_value;

   logic [TAG_W-1:0] res_tag  [0:DEPTH-1];
   logic             res_data [0:DEPTH-1];
   logic [PTR_W-1:0] res_wr;
   logic [PTR_W-1:0] res_rd;
   logic [PTR_W:0]   res_count;
   logic             wb_pop;

   logic [PTR_W:0]   credits;

   logic             unused_y;
   assign unused_y = ^cmp_y[31:1];

   always_comb begin
      req_kind = KIND_FLE;
      case (req_op)
         2'b01:   req_kind = KIND_FLT;
         2'b10:   req_kind = KIND_FEQ;
         default: req_kind = KIND_FLE;
      endcase
   end

   assign req_ready = (state == ST_IDLE) && (credits < DEPTH_C);
   assign accept    = req_valid & req_ready;
   assign wb_valid  = (res_count != '0);
   assign wb_pop    = wb_valid & wb_ready;
   assign pend_pop  = cmp_out_valid & (pend_count != '0);
   assign wb_tag    = res_tag[res_rd];
   assign wb_data   = {31'd0, res_data[res_rd]};

   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         state     <= ST_IDLE;
         cmp_valid <= 1'b0;
         cmp_x1    <= '0;
         cmp_x2    <= '0;
         lat_a     <= '0;
         lat_b     <= '0;
         lat_tag   <= '0;
      end else begin
         cmp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  cmp_valid <= 1'b1;
                  // flt(a,b) == !(b <= a)
                  if (req_kind == KIND_FLT) begin
                     cmp_x1 <= req_x2;
                     cmp_x2 <= req_x1;
                  end else begin
                     cmp_x1 <= req_x1;
                     cmp_x2 <= req_x2;
                  end
                  if (req_kind == KIND_FEQ) begin
                     lat_a   <= req_x1;
                     lat_b   <= req_x2;
                     lat_tag <= req_tag;
                     state   <= ST_ISSUE2;
                  end
               end
            end
            ST_ISSUE2: begin
               cmp_valid <= 1'b1;
               cmp_x1    <= lat_b;
               cmp_x2    <= lat_a;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign pend_push   = accept | (state == ST_ISSUE2);
   assign push_second = (state == ST_ISSUE2);
   assign push_tag    = push_second ? lat_tag : req_tag;
   assign push_kind   = push_second ? KIND_FEQ : req_kind;

   always_ff @(posedge sys_clk) begin
      if (pend_push) begin
         pend_tag[pend_wr]    <= push_tag;
         pend_kind[pend_wr]   <= push_kind;
         pend_second[pend_wr] <= push_second;
      end
   end

   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         pend_wr    <= '0;
         pend_rd    <= '0;
         pend_count <= '0;
      end else begin
         if (pend_push) pend_wr <= pend_wr + ONE_W;
         if (pend_pop)  pend_rd <= pend_rd + ONE_W;
         case ({pend_push, pend_pop})
            2'b10:   pend_count <= pend_count + ONE_PEND;
            2'b01:   pend_count <= pend_count - ONE_PEND;
            default: pend_count <= pend_count;
         endcase
      end
   end

   always_comb begin
      res_push  = 1'b0;
      res_value = 1'b0;
      if (pend_pop) begin
         case (pend_kind[pend_rd])
            KIND_FEQ: begin
               if (pend_second[pend_rd]) begin
                  res_push  = 1'b1;
                  res_value = hold & cmp_y[0];
               end
            end
            KIND_FLT: begin
               res_push  = 1'b1;
               res_value = ~cmp_y[0];
            end
            default: begin
               res_push  = 1'b1;
               res_value = cmp_y[0];
            end
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         hold <= 1'b0;
      end else if (pend_pop && (pend_kind[pend_rd] == KIND_FEQ) && !pend_second[pend_rd]) begin
         hold <= cmp_y[0];
      end
   end

   always_ff @(posedge sys_clk) begin
      if (res_push) begin
         res_tag[res_wr]  <= pend_tag[pend_rd];
         res_data[res_wr] <= res_value;
      end
   end

   // Space is guaranteed by the credit check at accept time.
   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         res_wr    <= '0;
         res_rd    <= '0;
         res_count <= '0;
      end else begin
         if (res_push) res_wr <= res_wr + ONE_W[PTR_W-1:0];
         if (wb_pop)   res_rd <= res_rd + ONE_W[PTR_W-1:0];
         case ({res_push, wb_pop})
            2'b10:   res_count <= res_count + ONE_W;
            2'b01:   res_count <= res_count - ONE_W;
            default: res_count <= res_count;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         credits <= '0;
      end else begin
         case ({accept, wb_pop})
            2'b10:   credits <= credits + ONE_W;
            2'b01:   credits <= credits - ONE_W;
            default: credits <= credits;
         endcase
      end
   end

`ifdef FPU_CMP_STATS_EN
   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         stat_issued <= '0;
         stat_stall  <= '0;
      end else begin
         if (accept)                 stat_issued <= stat_issued + 32'd1;
         if (req_valid && !req_ready) stat_stall <= stat_stall + 32'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpu_cmp_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_cmp_issuer
// Function : scoreboard bench for fpu_cmp_issuer with a behavioural compare unit.
// Revision : 1.0
// ============================================================================
module tb_fpu_cmp_issuer;

   localparam int TAG_W = 5;
   localparam int DEPTH = 4;

   logic             sys_clk = 1'b0;
   logic             rstn = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [1:0]       req_op = 2'b00;
   logic [TAG_W-1:0] req_tag = '0;
   logic [31:0]      req_x1 = '0;
   logic [31:0]      req_x2 = '0;
   logic             cmp_valid;
   logic [31:0]      cmp_x1;
   logic [31:0]      cmp_x2;
   logic [31:0]      cmp_y = '0;
   logic             cmp_out_valid = 1'b0;
   logic             wb_valid;
   logic             wb_ready = 1'b1;
   logic [TAG_W-1:0] wb_tag;
   logic [31:0]      wb_data;

   logic             inject = 1'b0;
   bit               rand_rdy = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [TAG_W:0]   exp_wb_q   [$];
   logic [63:0]      exp_beat_q [$];
   int               cred_m = 0;
   bit               issue2_m = 1'b0;
   logic             acc_m, pop_m;
   logic [TAG_W:0]   e_wb;
   logic [63:0]      e_beat;

   always #5 sys_clk = ~sys_clk;

   fpu_cmp_issuer #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
      .sys_clk       (sys_clk),
      .rstn          (rstn),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_op        (req_op),
      .req_tag       (req_tag),
      .req_x1        (req_x1),
      .req_x2        (req_x2),
      .cmp_valid     (cmp_valid),
      .cmp_x1        (cmp_x1),
      .cmp_x2        (cmp_x2),
      .cmp_y         (cmp_y),
      .cmp_out_valid (cmp_out_valid),
      .wb_valid      (wb_valid),
      .wb_ready      (wb_ready),
      .wb_tag        (wb_tag),
      .wb_data       (wb_data)
   );

   // total order for non-NaN singles with -0 < +0
   function automatic logic [31:0] fkey(input logic [31:0] v);
      return v[31] ? ~v : (v | 32'h8000_0000);
   endfunction

   function automatic logic fle(input logic [31:0] a, input logic [31:0] b);
      return fkey(a) <= fkey(b);
   endfunction

   // behavioural single-cycle compare unit
   always @(posedge sys_clk) begin
      cmp_out_valid <= cmp_valid | inject;
      cmp_y         <= fle(cmp_x1, cmp_x2) ? 32'hFFFF_FFFF : 32'h0;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge sys_clk) begin
      if (!rstn) begin
         exp_wb_q.delete();
         exp_beat_q.delete();
         cred_m   = 0;
         issue2_m = 1'b0;
      end else begin
         check("req_ready", {63'd0, req_ready}, {63'd0, (!issue2_m && cred_m < DEPTH)});
         if (cmp_valid) begin
            check("beat_expected", {63'd0, exp_beat_q.size() != 0}, 64'd1);
            if (exp_beat_q.size() != 0) begin
               e_beat = exp_beat_q.pop_front();
               check("beat_operands", {cmp_x1, cmp_x2}, e_beat);
            end
         end
         if (wb_valid && wb_ready) begin
            check("wb_expected", {63'd0, exp_wb_q.size() != 0}, 64'd1);
            if (exp_wb_q.size() != 0) begin
               e_wb = exp_wb_q.pop_front();
               check("wb_result", {27'd0, wb_tag, wb_data}, {27'd0, e_wb[TAG_W:1], 31'd0, e_wb[0]});
            end
         end
         acc_m = req_valid && req_ready;
         pop_m = wb_valid && wb_ready;
         if (acc_m) begin
            case (req_op)
               2'b01: begin
                  exp_beat_q.push_back({req_x2, req_x1});
                  exp_wb_q.push_back({req_tag, !fle(req_x2, req_x1)});
               end
               2'b10: begin
                  exp_beat_q.push_back({req_x1, req_x2});
                  exp_beat_q.push_back({req_x2, req_x1});
                  exp_wb_q.push_back({req_tag, fle(req_x1, req_x2) && fle(req_x2, req_x1)});
               end
               default: begin
                  exp_beat_q.push_back({req_x1, req_x2});
                  exp_wb_q.push_back({req_tag, fle(req_x1, req_x2)});
               end
            endcase
         end
         cred_m   = cred_m + int'(acc_m) - int'(pop_m);
         issue2_m = acc_m && (req_op == 2'b10);
      end
   end

   initial begin
      forever begin
         @(posedge sys_clk);
         #1;
         if (rand_rdy) wb_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // called aligned at posedge+1; returns aligned at posedge+1 after the accept edge
   task automatic send(input logic [1:0] op, input logic [TAG_W-1:0] tag,
                       input logic [31:0] a, input logic [31:0] b);
      int n;
      n = 0;
      req_valid = 1'b1;
      req_op    = op;
      req_tag   = tag;
      req_x1    = a;
      req_x2    = b;
      @(negedge sys_clk);
      while (!req_ready && n < 200) begin
         @(negedge sys_clk);
         n++;
      end
      check("send_accepted", {63'd0, req_ready}, 64'd1);
      @(posedge sys_clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      wb_ready = 1'b1;
      while ((exp_wb_q.size() != 0 || exp_beat_q.size() != 0) && n < 300) begin
         @(posedge sys_clk);
         n++;
      end
      check("drain_done", {63'd0, exp_wb_q.size() == 0 && exp_beat_q.size() == 0}, 64'd1);
      @(posedge sys_clk);
      #1;
   endtask

   logic [31:0] vals [0:5];
   logic [31:0] va, vb;
   int          accepted;

   initial begin
      vals[0] = 32'h0000_0000; vals[1] = 32'h8000_0000; vals[2] = 32'h3F80_0000;
      vals[3] = 32'h4000_0000; vals[4] = 32'hBF80_0000; vals[5] = 32'hC040_0000;

      rstn = 1'b0;
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      check("rst_cmp_valid", {63'd0, cmp_valid}, 64'd0);
      check("rst_wb_valid",  {63'd0, wb_valid},  64'd0);
      check("rst_req_ready", {63'd0, req_ready}, 64'd1);
      @(posedge sys_clk);
      #1;
      rstn = 1'b1;
      @(posedge sys_clk);
      #1;

      // fle latency
      send(2'b00, 5'd3, 32'h3F80_0000, 32'h4000_0000);
      @(negedge sys_clk);
      check("fle_beat_n1", {63'd0, cmp_valid}, 64'd1);
      @(negedge sys_clk);
      check("fle_wb_n1", {63'd0, wb_valid}, 64'd0);
      @(negedge sys_clk);
      check("fle_wb_n2", {63'd0, wb_valid}, 64'd1);
      check("fle_data", {27'd0, wb_tag, wb_data}, {27'd0, 5'd3, 32'd1});
      @(posedge sys_clk);
      #1;

      // flt
      send(2'b01, 5'd7, 32'h4000_0000, 32'h3F80_0000);
      repeat (2) @(negedge sys_clk);
      @(negedge sys_clk);
      check("flt_data", {27'd0, wb_valid, wb_tag, wb_data}, {27'd0, 1'b1, 5'd7, 32'd0});
      @(posedge sys_clk);
      #1;

      // feq two beats, ready low during ISSUE2, result at N+3
      send(2'b10, 5'd1, 32'h3F80_0000, 32'h3F80_0000);
      @(negedge sys_clk);
      check("feq_issue2_ready", {63'd0, req_ready}, 64'd0);
      @(negedge sys_clk);
      @(negedge sys_clk);
      check("feq_wb_n2", {63'd0, wb_valid}, 64'd0);
      @(negedge sys_clk);
      check("feq_data", {27'd0, wb_valid, wb_tag, wb_data}, {27'd0, 1'b1, 5'd1, 32'd1});
      @(posedge sys_clk);
      #1;
      send(2'b10, 5'd2, 32'h0000_0000, 32'h8000_0000);
      send(2'b00, 5'd4, 32'h0000_0000, 32'h8000_0000);
      send(2'b01, 5'd5, 32'h8000_0000, 32'h0000_0000);
      send(2'b11, 5'd6, 32'hBF80_0000, 32'h3F80_0000);
      drain();

      // fill with writeback stalled
      wb_ready  = 1'b0;
      accepted  = 0;
      req_valid = 1'b1;
      req_op    = 2'b00;
      req_tag   = 5'd10;
      for (int c = 0; c < 10 && accepted < 6; c++) begin
         req_x1 = vals[c % 6];
         req_x2 = vals[(c + 3) % 6];
         @(negedge sys_clk);
         if (req_ready) accepted++;
         @(posedge sys_clk);
         #1;
         req_tag = 5'(10 + accepted);
      end
      req_valid = 1'b0;
      check("fill_accepts", accepted, 64'd4);
      @(negedge sys_clk);
      check("fill_ready_low", {63'd0, req_ready}, 64'd0);
      @(posedge sys_clk);
      #1;
      wb_ready = 1'b1;
      @(negedge sys_clk);
      check("ready_at_pop", {63'd0, req_ready}, 64'd0);
      @(negedge sys_clk);
      check("ready_after_pop", {63'd0, req_ready}, 64'd1);
      @(posedge sys_clk);
      #1;
      drain();

      // alternating fle/feq with random writeback back-pressure
      rand_rdy = 1'b1;
      for (int i = 0; i < 60; i++) begin
         va = vals[$urandom_range(0, 5)];
         vb = ($urandom_range(0, 2) == 0) ? va : vals[$urandom_range(0, 5)];
         send((i % 2 == 1) ? 2'b10 : 2'b00, 5'(i), va, vb);
      end
      rand_rdy = 1'b0;
      @(posedge sys_clk);
      #1;
      drain();

      // asynchronous reset with beats in flight and results buffered
      wb_ready = 1'b0;
      send(2'b00, 5'd20, 32'h3F80_0000, 32'h4000_0000);
      send(2'b00, 5'd21, 32'h4000_0000, 32'h3F80_0000);
      send(2'b10, 5'd22, 32'h3F80_0000, 32'h3F80_0000);
      @(posedge sys_clk);
      #3;
      rstn = 1'b0;
      #1;
      check("arst_wb_valid",  {63'd0, wb_valid},  64'd0);
      check("arst_cmp_valid", {63'd0, cmp_valid}, 64'd0);
      repeat (2) @(posedge sys_clk);
      #1;
      rstn     = 1'b1;
      wb_ready = 1'b1;
      inject   = 1'b1;
      @(posedge sys_clk);
      #1;
      inject = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge sys_clk);
         check("stray_wb_valid", {63'd0, wb_valid}, 64'd0);
      end
      check("post_rst_ready", {63'd0, req_ready}, 64'd1);
      @(posedge sys_clk);
      #1;
      send(2'b10, 5'd9, 32'hBF80_0000, 32'hBF80_0000);
      send(2'b00, 5'd8, 32'h4000_0000, 32'h3F80_0000);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
